oam_dma_engine: RTL

//  Sprite DMA unit sitting directly downstream of the CPU core on the system bus.
//  - Snoops CPU writes to $4014.
//  - Stalls the CPU and copies 256 bytes from page {data,8'h00} into the PPU
//    OAM data port ($2004).
//  - Drives the shared bus while active. The top level muxes dma_* over the
//    CPU's aout/dout/mr/mw and gates the CPU clock enable with ~cpu_pause.

---
 rtl/oam_dma_engine.sv | 115 +++++++++++
 1 files changed

// File: rtl/oam_dma_engine.sv
// Sprite DMA engine: snoops CPU writes to the trigger register, stalls the CPU
// and copies one 256-byte page into the PPU OAM data port, one byte per get/put pair.
module oam_dma_engine #(
  parameter logic [15:0] REG_ADDR  = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mw,
  input  logic [7:0]  mem_din,
  output logic        cpu_pause,
  output logic        dma_active,
  output logic [15:0] dma_aout,
  output logic [7:0]  dma_dout,
  output logic        dma_mr,
  output logic        dma_mw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       odd_q;

  // State register; odd_q tracks get (0) / put (1) cycle parity.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
      odd_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      odd_q   <= ~odd_q;
    end
  end

  // Next-state logic.
  // NOTE: every signal written here gets a hold default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_mw && cpu_aout == REG_ADDR) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      // The halt cycle on a put means the next cycle is a get: go straight to READ.
      S_HALT:  state_d = odd_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        latch_d = mem_din;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so an async reset drops them at once.
  always_comb begin
    cpu_pause  = (state_q != S_IDLE);
    dma_active = (state_q != S_IDLE);
    dma_aout   = 16'h0000;
    dma_dout   = 8'h00;
    dma_mr     = 1'b0;
    dma_mw     = 1'b0;
    unique case (state_q)
      S_READ: begin
        dma_aout = {page_q, idx_q};
        dma_mr   = 1'b1;
      end
      S_WRITE: begin
        dma_aout = DEST_ADDR;
        dma_dout = latch_q;
        dma_mw   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
